// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC register and instruction-fetch stage of the RV32I pipeline.
// Issues requests to a variable-latency instruction memory and fills the
// IF/ID pipeline register. Stalls hold the register, redirects squash younger
// fetches, and a one-entry hold buffer catches a response that lands during a stall.
// Optional feature: define IF_MISALIGN_CHK_EN to trap misaligned redirect
// targets (misalign_o port plus a HALT state). Without it, target bits [1:0]
// are silently masked.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic [31:0] pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic        misalign_o
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DROP = 3'd2,
        ST_HOLD = 3'd3
`ifdef IF_MISALIGN_CHK_EN
        ,
        ST_HALT = 3'd4
`endif
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic        req_r;
    logic [31:0] addr_r;
    logic [31:0] if_id_pc_r;
    logic [31:0] if_id_instr_r;
    logic        if_id_valid_r;
    logic [31:0] hold_pc_r;
    logic [31:0] hold_instr_r;
    logic        hold_valid_r;
    logic [31:0] npc_aligned_s;
    logic        req_pending_s;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign_r;
    logic        bad_target_s;
`endif

    // Word-aligned next PC and whether the current request will still be
    // waiting for its response after this edge.
    always_comb begin
        npc_aligned_s = npc_i & 32'hFFFF_FFFC;
        req_pending_s = 1'b0;
        if (req_r && !imem_ready_i) begin
            req_pending_s = 1'b1;
        end else begin
            req_pending_s = 1'b0;
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    // Flag a redirect target that is not word aligned.
    always_comb begin
        bad_target_s = 1'b0;
        if (redirect_i && (npc_i[1:0] != 2'b00)) begin
            bad_target_s = 1'b1;
        end else begin
            bad_target_s = 1'b0;
        end
    end
`endif

    // Fetch FSM: PC, memory request, IF/ID register and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            req_r         <= 1'b0;
            addr_r        <= RESET_PC;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_instr_r <= NOP_INSTR;
            if_id_valid_r <= 1'b0;
            hold_pc_r     <= 32'h0000_0000;
            hold_instr_r  <= NOP_INSTR;
            hold_valid_r  <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
            misalign_r    <= 1'b0;
`endif
        end else if (redirect_i) begin
            // Squash whatever is in flight; stall is ignored this cycle.
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= NOP_INSTR;
            hold_valid_r  <= 1'b0;
            hold_instr_r  <= NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
            misalign_r    <= bad_target_s;
            if (bad_target_s) begin
                // Keep the faulting target visible and stop fetching.
                pc_r    <= npc_i;
                req_r   <= 1'b0;
                state_r <= ST_HALT;
            end else
`endif
            if (req_pending_s) begin
                // The stale response must still be drained at the old address.
                pc_r    <= npc_aligned_s;
                state_r <= ST_DROP;
            end else begin
                pc_r    <= npc_aligned_s;
                req_r   <= 1'b1;
                addr_r  <= npc_aligned_s;
                state_r <= ST_REQ;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    req_r   <= 1'b1;
                    addr_r  <= pc_r;
                    state_r <= ST_REQ;
                end
                ST_REQ: begin
                    if (imem_ready_i && stall_i) begin
                        // Park the response until ID can take it.
                        hold_pc_r    <= pc_r;
                        hold_instr_r <= imem_rdata_i;
                        hold_valid_r <= 1'b1;
                        pc_r         <= npc_aligned_s;
                        req_r        <= 1'b0;
                        state_r      <= ST_HOLD;
                    end else if (imem_ready_i) begin
                        if_id_pc_r    <= pc_r;
                        if_id_instr_r <= imem_rdata_i;
                        if_id_valid_r <= 1'b1;
                        pc_r          <= npc_aligned_s;
                        addr_r        <= npc_aligned_s;
                    end else if (stall_i) begin
                        // Hold IF/ID and PC; the request stays asserted.
                        state_r <= ST_REQ;
                    end else begin
                        // Memory still busy: ID sees a bubble.
                        if_id_valid_r <= 1'b0;
                        if_id_instr_r <= NOP_INSTR;
                    end
                end
                ST_DROP: begin
                    if (imem_ready_i) begin
                        // Stale response discarded; fetch the redirect target.
                        req_r   <= 1'b1;
                        addr_r  <= pc_r;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        if_id_pc_r    <= hold_pc_r;
                        if_id_instr_r <= hold_instr_r;
                        if_id_valid_r <= hold_valid_r;
                        hold_valid_r  <= 1'b0;
                        req_r         <= 1'b1;
                        addr_r        <= pc_r;
                        state_r       <= ST_REQ;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
`ifdef IF_MISALIGN_CHK_EN
                ST_HALT: begin
                    req_r   <= 1'b0;
                    state_r <= ST_HALT;
                end
`endif
                default: begin
                    req_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc_o          = pc_r;
    assign imem_req_o    = req_r;
    assign imem_addr_o   = addr_r;
    assign if_id_pc_o    = if_id_pc_r;
    assign if_id_instr_o = if_id_instr_r;
    assign if_id_valid_o = if_id_valid_r;
`ifdef IF_MISALIGN_CHK_EN
    assign misalign_o    = misalign_r;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed-vector bench for if_fetch_unit.
// Covers zero-wait streaming, delayed memory, stall with hold buffer,
// redirect drop, redirect+stall, and misaligned redirect in both
// IF_MISALIGN_CHK_EN builds.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] npc_i;
    logic        redirect_i;
    logic        stall_i;
    logic [31:0] pc_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
`ifdef IF_MISALIGN_CHK_EN
    logic        misalign_o;
`endif

    int checks;
    int errors;

    if_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .npc_i         (npc_i),
        .redirect_i    (redirect_i),
        .stall_i       (stall_i),
        .pc_o          (pc_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_valid_o (if_id_valid_o)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic cyc(input logic rdy, input logic [31:0] rd, input logic st,
                       input logic rdr, input logic [31:0] np);
        imem_ready_i = rdy;
        imem_rdata_i = rd;
        stall_i      = st;
        redirect_i   = rdr;
        npc_i        = np;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic vld);
        check_val({tag, "_ifid_pc"}, if_id_pc_o, pc);
        check_val({tag, "_ifid_instr"}, if_id_instr_o, instr);
        check_val({tag, "_ifid_valid"}, {31'd0, if_id_valid_o}, {31'd0, vld});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        check_val({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
        if (req) begin
            check_val({tag, "_addr"}, imem_addr_o, addr);
        end else begin
            check_val({tag, "_addr_skip"}, {31'd0, imem_req_o}, 32'd0);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        npc_i        = 32'h0;
        redirect_i   = 1'b0;
        stall_i      = 1'b0;
        imem_ready_i = 1'b0;
        imem_rdata_i = 32'h0;

        // Reset state
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_val("rst_pc", pc_o, 32'h0);
        check_val("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk_ifid("rst", 32'h0, NOP, 1'b0);
`ifdef IF_MISALIGN_CHK_EN
        check_val("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif
        rst = 1'b0;

        // Streaming with zero-wait memory
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h4);           // IDLE -> REQ
        chk_req("e1", 1'b1, 32'h0);
        chk_ifid("e1", 32'h0, NOP, 1'b0);
        cyc(1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h4);
        chk_ifid("e2", 32'h0, 32'hA000_0000, 1'b1);
        check_val("e2_pc", pc_o, 32'h4);
        cyc(1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h8);
        chk_ifid("e3", 32'h4, 32'hA000_0004, 1'b1);
        check_val("e3_pc", pc_o, 32'h8);

        // Memory delayed 3 cycles at pc=8
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'hC);
            chk_req("wait", 1'b1, 32'h8);
            check_val("wait_valid", {31'd0, if_id_valid_o}, 32'd0);
            check_val("wait_pc", pc_o, 32'h8);
        end
        cyc(1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'hC);
        chk_ifid("e7", 32'h8, 32'hA000_0008, 1'b1);
        cyc(1'b1, 32'hA000_000C, 1'b0, 1'b0, 32'h10);
        chk_ifid("e8", 32'hC, 32'hA000_000C, 1'b1);
        check_val("e8_pc", pc_o, 32'h10);

        // Ready at pc=10 during a 2-cycle stall
        cyc(1'b1, 32'hA000_0010, 1'b1, 1'b0, 32'h14);
        chk_ifid("st1", 32'hC, 32'hA000_000C, 1'b1);
        chk_req("st1", 1'b0, 32'h0);
        check_val("st1_pc", pc_o, 32'h14);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h18);
        chk_ifid("st2", 32'hC, 32'hA000_000C, 1'b1);
        chk_req("st2", 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h18);
        chk_ifid("unst", 32'h10, 32'hA000_0010, 1'b1);
        chk_req("unst", 1'b1, 32'h14);
        cyc(1'b1, 32'hA000_0014, 1'b0, 1'b0, 32'h18);
        chk_ifid("e12", 32'h14, 32'hA000_0014, 1'b1);
        cyc(1'b1, 32'hA000_0018, 1'b0, 1'b0, 32'h1C);
        cyc(1'b1, 32'hA000_001C, 1'b0, 1'b0, 32'h20);
        chk_ifid("e14", 32'h1C, 32'hA000_001C, 1'b1);
        chk_req("e14", 1'b1, 32'h20);

        // Redirect to 40 while request at 20 is outstanding
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        check_val("rd_pc", pc_o, 32'h40);
        chk_req("rd", 1'b1, 32'h20);
        chk_ifid("rd", 32'h1C, NOP, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h44);
        chk_req("drop_wait", 1'b1, 32'h20);
        check_val("drop_wait_valid", {31'd0, if_id_valid_o}, 32'd0);
        cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h44);
        check_val("dropped_valid", {31'd0, if_id_valid_o}, 32'd0);
        check_val("dropped_instr", if_id_instr_o, NOP);
        chk_req("after_drop", 1'b1, 32'h40);
        cyc(1'b1, 32'hA000_0040, 1'b0, 1'b0, 32'h44);
        chk_ifid("e18", 32'h40, 32'hA000_0040, 1'b1);

        // Redirect and stall together
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
        check_val("rs_pc", pc_o, 32'h80);
        check_val("rs_valid", {31'd0, if_id_valid_o}, 32'd0);
        check_val("rs_instr", if_id_instr_o, NOP);
        cyc(1'b1, 32'hBAD0_0044, 1'b0, 1'b0, 32'h84);
        chk_req("rs_drop", 1'b1, 32'h80);
        check_val("rs_drop_valid", {31'd0, if_id_valid_o}, 32'd0);
        cyc(1'b1, 32'hA000_0080, 1'b0, 1'b0, 32'h84);
        chk_ifid("e21", 32'h80, 32'hA000_0080, 1'b1);

        // Misaligned redirect target 0x42
        cyc(1'b1, 32'hBAD0_0084, 1'b0, 1'b1, 32'h42);
`ifdef IF_MISALIGN_CHK_EN
        check_val("mis_flag", {31'd0, misalign_o}, 32'd1);
        chk_req("mis", 1'b0, 32'h0);
        check_val("mis_valid", {31'd0, if_id_valid_o}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h50);
        check_val("halt_flag", {31'd0, misalign_o}, 32'd1);
        chk_req("halt", 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h44);
        check_val("unhalt_flag", {31'd0, misalign_o}, 32'd0);
        chk_req("unhalt", 1'b1, 32'h44);
        check_val("unhalt_pc", pc_o, 32'h44);
        cyc(1'b1, 32'hA000_0044, 1'b0, 1'b0, 32'h48);
        chk_ifid("e25", 32'h44, 32'hA000_0044, 1'b1);
`else
        check_val("mask_pc", pc_o, 32'h40);
        chk_req("mask", 1'b1, 32'h40);
        check_val("mask_valid", {31'd0, if_id_valid_o}, 32'd0);
        cyc(1'b1, 32'hA000_0040, 1'b0, 1'b0, 32'h44);
        chk_ifid("e23", 32'h40, 32'hA000_0040, 1'b1);
`endif

        // Reset while a request is outstanding
        rst = 1'b1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check_val("rst2_pc", pc_o, 32'h0);
        check_val("rst2_req", {31'd0, imem_req_o}, 32'd0);
        chk_ifid("rst2", 32'h0, NOP, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
